lcd_panel_sequencer: RTL and testbench
======================================

Name: lcd_panel_sequencer

Overview:
- Power-up/power-down and pattern scheduler for the RGB LCD test-pattern path.
- Gates the timing generator's run enable.
- Drives the panel DISP and backlight enables in the required order, counting frames from the generator's LCD_VSYNC.
- Selects the active test pattern and allows pattern changes only at frame boundaries, so no frame tears.

Parameters:
- POWER_DLY, 16'd1000, PixelClk cycles in PWR_WAIT before the timing generator starts (min 1).
- STARTUP_FRAMES, 4'd2, frames of running sync before DISP is asserted (min 1).
- BL_FRAMES, 4'd1, frames after DISP before the backlight turns on (min 1).
- OFF_FRAMES, 4'd1, frames spent in each shutdown step (min 1).
- NUM_PATTERNS, 3'd7, number of selectable patterns; pattern_sel wraps to 0 after NUM_PATTERNS-1.
- AUTO_FRAMES, 8'd60, frames per pattern in auto-cycle mode (optional feature only).

Ports:
- PixelClk, in, 1, pixel clock; all logic is on the rising edge.
- nRST, in, 1, synchronous active-low reset.
- power_req, in, 1, level: 1 = panel on requested, 0 = off requested.
- LCD_VSYNC, in, 1, vertical sync from the timing generator, active low.
- pattern_next, in, 1, single-cycle pulse requesting advance to the next pattern.
- tg_en, out, 1, run enable to the timing generator.
- panel_disp, out, 1, panel DISP pin.
- bl_en, out, 1, backlight enable.
- pattern_sel, out, 3, active pattern index.
- ready, out, 1, high only in state ON.
- busy, out, 1, high in any state other than OFF and ON.

Behaviour:
- Reset (nRST low at a clock edge):
  - state=OFF; all outputs 0; pattern_sel=0.
  - vs_prev=1; frame counter, delay counter and pending flag cleared.
  - Reset wins over every other event, including mid-sequence: outputs drop to 0 the same edge.
- frame_tick:
  - 1-cycle internal pulse, registered: high the cycle after a PixelClk edge that samples LCD_VSYNC=0 while vs_prev=1.
  - Only counted while tg_en=1.
- Frame counter: 4 bits, cleared on every state entry, incremented on frame_tick. Exit condition for a step is count==N reached on a tick.
- States and transitions (all outputs registered, changing the cycle after the transition):
  - OFF: outputs 0. power_req=1 -> PWR_WAIT.
  - PWR_WAIT: delay counter counts POWER_DLY cycles, then -> SYNC_RUN. power_req=0 -> OFF immediately.
  - SYNC_RUN: tg_en=1. After STARTUP_FRAMES ticks -> DISP_ON. power_req=0 -> OFF, with tg_en=0.
  - DISP_ON: tg_en=1, panel_disp=1. After BL_FRAMES ticks -> ON. power_req=0 -> DISP_OFF.
  - ON: tg_en, panel_disp, bl_en, ready all 1. power_req=0 -> BL_OFF.
  - BL_OFF: bl_en=0. After OFF_FRAMES ticks -> DISP_OFF.
  - DISP_OFF: panel_disp=0, tg_en=1. After OFF_FRAMES ticks -> OFF.
- Shutdown ordering:
  - Shutdown is never aborted: power_req returning to 1 during BL_OFF or DISP_OFF is ignored until OFF is reached.
  - From OFF, the normal power_req=1 transition then applies.
- Pattern change:
  - pattern_next sets a pending flag in any state.
  - The pending flag applies on the next frame_tick: pattern_sel increments, wrapping at NUM_PATTERNS-1 -> 0, and the flag clears.
  - Multiple pulses within one frame give a single increment.
  - A pulse arriving in the same cycle as a frame_tick is applied on that tick.
  - In OFF or PWR_WAIT (no ticks), the flag is held until the first tick.
- pattern_sel keeps its value across a power cycle; only reset clears it.

Optional Feature:
- Macro: LCD_PATTERN_AUTO_CYCLE_EN.
- Defined:
  - An 8-bit frame counter runs in ON only.
  - Every AUTO_FRAMES ticks it generates an internal pattern advance, applied at the same tick.
  - The counter clears on entering ON and whenever a manual advance is applied.
- Undefined: the counter and its logic are absent; patterns change only via pattern_next.

Test Plan:
- Reset: nRST=0 for 3 cycles with power_req=1 -> all outputs 0 and pattern_sel=0. With VSYNC period 100 cycles, POWER_DLY=16, STARTUP=2, BL=1 -> tg_en rises 16 cycles after PWR_WAIT entry, panel_disp after 2 VSYNC falls, bl_en and ready after 1 more.
- Shutdown from ON: power_req 1->0 -> bl_en falls the next cycle; panel_disp falls after 1 VSYNC fall; tg_en falls after 1 more; busy high throughout and low in OFF.
- Abort: power_req drops 5 cycles into PWR_WAIT -> OFF next cycle, tg_en never asserted. Drop during DISP_ON -> DISP_OFF, bl_en never asserted.
- Pattern: three pattern_next pulses within one frame while ON with pattern_sel=6 and NUM_PATTERNS=7 -> pattern_sel=0 exactly one cycle after the next tick, with no change mid-frame.
- Request during shutdown: power_req re-raised in BL_OFF -> full shutdown to OFF, then PWR_WAIT entered the following cycle.
- Auto-cycle (LCD_PATTERN_AUTO_CYCLE_EN defined, AUTO_FRAMES=3): in ON, pattern_sel increments on every 3rd tick. A manual pulse at tick 2 advances the pattern at that tick and restarts the 3-frame count.

Source files
------------

// File: rtl/lcd_panel_sequencer.sv
// lcd_panel_sequencer: panel power sequencing and frame-aligned test pattern select.
// Define LCD_PATTERN_AUTO_CYCLE_EN to advance the pattern every AUTO_FRAMES frames in ON.
module lcd_panel_sequencer #(
    parameter logic [15:0] POWER_DLY      = 16'd1000,
    parameter logic [3:0]  STARTUP_FRAMES = 4'd2,
    parameter logic [3:0]  BL_FRAMES      = 4'd1,
    parameter logic [3:0]  OFF_FRAMES     = 4'd1,
`ifdef LCD_PATTERN_AUTO_CYCLE_EN
    parameter logic [7:0]  AUTO_FRAMES    = 8'd60,
`endif
    parameter logic [2:0]  NUM_PATTERNS   = 3'd7
) (
    input  logic       PixelClk,
    input  logic       nRST,
    input  logic       power_req,
    input  logic       LCD_VSYNC,
    input  logic       pattern_next,
    output logic       tg_en,
    output logic       panel_disp,
    output logic       bl_en,
    output logic [2:0] pattern_sel,
    output logic       ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_OFF, S_PWR_WAIT, S_SYNC_RUN, S_DISP_ON, S_ON, S_BL_OFF, S_DISP_OFF
    } state_t;

    state_t      state_q, state_d;
    logic        vs_prev_q, tick_q, tick_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [15:0] dly_q, dly_d;
    logic        pend_q, pend_d;
    logic [2:0]  pat_q, pat_d;
    logic        tg_en_q, tg_en_d, disp_q, disp_d, bl_q, bl_d;
    logic        ready_q, ready_d, busy_q, busy_d;
    logic        ftick, manual, advance;

    // Frame ticks only count while the timing generator is running.
    assign tick_d = vs_prev_q & ~LCD_VSYNC;
    assign ftick  = tick_q & tg_en_q;
    assign manual = ftick & (pend_q | pattern_next);

`ifdef LCD_PATTERN_AUTO_CYCLE_EN
    logic [7:0] acnt_q, acnt_d;
    logic       auto_adv;

    always_comb begin
        acnt_d   = acnt_q;
        auto_adv = 1'b0;
        if (state_q != S_ON) begin
            acnt_d = 8'd0;
        end else if (ftick) begin
            if (manual) begin
                acnt_d = 8'd0;
            end else if (acnt_q == AUTO_FRAMES - 8'd1) begin
                auto_adv = 1'b1;
                acnt_d   = 8'd0;
            end else begin
                acnt_d = acnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) acnt_q <= 8'd0;
        else       acnt_q <= acnt_d;
    end

    assign advance = manual | auto_adv;
`else
    assign advance = manual;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF: if (power_req) state_d = S_PWR_WAIT;
            S_PWR_WAIT: begin
                if (!power_req)                       state_d = S_OFF;
                else if (dly_q == POWER_DLY - 16'd1) state_d = S_SYNC_RUN;
            end
            S_SYNC_RUN: begin
                if (!power_req) state_d = S_OFF;
                else if (ftick && fcnt_q == STARTUP_FRAMES - 4'd1)
                    state_d = S_DISP_ON;
            end
            S_DISP_ON: begin
                if (!power_req) state_d = S_DISP_OFF;
                else if (ftick && fcnt_q == BL_FRAMES - 4'd1)
                    state_d = S_ON;
            end
            S_ON: if (!power_req) state_d = S_BL_OFF;
            S_BL_OFF:
                if (ftick && fcnt_q == OFF_FRAMES - 4'd1) state_d = S_DISP_OFF;
            S_DISP_OFF:
                if (ftick && fcnt_q == OFF_FRAMES - 4'd1) state_d = S_OFF;
            default: state_d = S_OFF;
        endcase

        dly_d = (state_q == S_PWR_WAIT) ? dly_q + 16'd1 : 16'd0;
        if (state_d != state_q) fcnt_d = 4'd0;
        else if (ftick)         fcnt_d = fcnt_q + 4'd1;
        else                    fcnt_d = fcnt_q;

        tg_en_d = state_d inside {S_SYNC_RUN, S_DISP_ON, S_ON, S_BL_OFF, S_DISP_OFF};
        disp_d  = state_d inside {S_DISP_ON, S_ON, S_BL_OFF};
        bl_d    = (state_d == S_ON);
        ready_d = (state_d == S_ON);
        busy_d  = !(state_d inside {S_OFF, S_ON});

        pend_d = manual ? 1'b0 : (pend_q | pattern_next);
        pat_d  = pat_q;
        if (advance)
            pat_d = (pat_q == NUM_PATTERNS - 3'd1) ? 3'd0 : pat_q + 3'd1;
    end

    always_ff @(posedge PixelClk) begin
        if (!nRST) begin
            state_q   <= S_OFF;
            vs_prev_q <= 1'b1;
            tick_q    <= 1'b0;
            fcnt_q    <= 4'd0;
            dly_q     <= 16'd0;
            pend_q    <= 1'b0;
            pat_q     <= 3'd0;
            tg_en_q   <= 1'b0;
            disp_q    <= 1'b0;
            bl_q      <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs_prev_q <= LCD_VSYNC;
            tick_q    <= tick_d;
            fcnt_q    <= fcnt_d;
            dly_q     <= dly_d;
            pend_q    <= pend_d;
            pat_q     <= pat_d;
            tg_en_q   <= tg_en_d;
            disp_q    <= disp_d;
            bl_q      <= bl_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign tg_en       = tg_en_q;
    assign panel_disp  = disp_q;
    assign bl_en       = bl_q;
    assign ready       = ready_q;
    assign busy        = busy_q;
    assign pattern_sel = pat_q;

endmodule

// File: tb/tb_lcd_panel_sequencer.sv
// Testbench for lcd_panel_sequencer: vector table, directed sequences, random vs model.
// LCD_PATTERN_AUTO_CYCLE_EN enables the auto-cycle checks (AUTO_FRAMES=3).
module tb_lcd_panel_sequencer;

    localparam int PDLY = 16;
    localparam int SF   = 2;
    localparam int BF   = 1;
    localparam int OF   = 1;
    localparam int NP   = 7;
    localparam int AF   = 3;

    logic       clk = 1'b0;
    logic       nRST = 1'b0;
    logic       power_req = 1'b0;
    logic       LCD_VSYNC = 1'b1;
    logic       pattern_next = 1'b0;
    logic       tg_en, panel_disp, bl_en, ready, busy;
    logic [2:0] pattern_sel;

    int n_checks = 0;
    int n_err    = 0;

    lcd_panel_sequencer #(
        .POWER_DLY(16'd16),
        .STARTUP_FRAMES(4'd2),
        .BL_FRAMES(4'd1),
        .OFF_FRAMES(4'd1),
`ifdef LCD_PATTERN_AUTO_CYCLE_EN
        .AUTO_FRAMES(8'd3),
`endif
        .NUM_PATTERNS(3'd7)
    ) dut (
        .PixelClk(clk),
        .nRST(nRST),
        .power_req(power_req),
        .LCD_VSYNC(LCD_VSYNC),
        .pattern_next(pattern_next),
        .tg_en(tg_en),
        .panel_disp(panel_disp),
        .bl_en(bl_en),
        .pattern_sel(pattern_sel),
        .ready(ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 off, 1 power wait, 2 sync, 3 disp on,
    // 4 on, 5 backlight off, 6 disp off. Steps count down to zero.
    int m_ph, m_left, m_wait, m_pat, m_since;
    bit m_vs, m_tick, m_pend;

    function automatic logic [4:0] m_outs(int ph);
        case (ph)
            1:       return 5'b00001;
            2:       return 5'b10001;
            3:       return 5'b11001;
            4:       return 5'b11110;
            5:       return 5'b11001;
            6:       return 5'b10001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int frames_for(int ph);
        case (ph)
            2:       return SF;
            3:       return BF;
            5, 6:    return OF;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        logic [4:0] o;
        bit counted, newtick, man, adv;
        int nxt;
        if (!nRST) begin
            m_ph = 0; m_vs = 1; m_tick = 0; m_pend = 0;
            m_pat = 0; m_left = 0; m_wait = 0; m_since = 0;
            return;
        end
        o       = m_outs(m_ph);
        counted = m_tick && o[4];
        newtick = m_vs && !LCD_VSYNC;
        m_vs    = LCD_VSYNC;
        man     = counted && (m_pend || pattern_next);
        adv     = man;
`ifdef LCD_PATTERN_AUTO_CYCLE_EN
        if (m_ph == 4 && counted && !man) begin
            m_since++;
            if (m_since == AF) begin
                adv = 1;
                m_since = 0;
            end
        end
        if (man) m_since = 0;
`endif
        if (adv) m_pat = (m_pat + 1) % NP;
        m_pend = man ? 1'b0 : (m_pend || pattern_next);
        if (counted) m_left--;
        nxt = m_ph;
        case (m_ph)
            0: if (power_req) nxt = 1;
            1: begin
                if (!power_req) nxt = 0;
                else begin
                    m_wait--;
                    if (m_wait == 0) nxt = 2;
                end
            end
            2: if (!power_req) nxt = 0; else if (m_left == 0) nxt = 3;
            3: if (!power_req) nxt = 6; else if (m_left == 0) nxt = 4;
            4: if (!power_req) nxt = 5;
            5: if (m_left == 0) nxt = 6;
            6: if (m_left == 0) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_ph) begin
            m_left  = frames_for(nxt);
            m_wait  = PDLY;
            m_since = 0;
        end
        m_ph   = nxt;
        m_tick = newtick;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic vs_tick();
        LCD_VSYNC = 1'b0;
        cyc();
        LCD_VSYNC = 1'b1;
        cyc();
    endtask

    task automatic bring_up(output int lat);
        power_req = 1'b1;
        lat = 0;
        while (!tg_en && lat < 40) begin
            cyc();
            lat++;
        end
        repeat (SF + BF) begin
            repeat (30) cyc();
            vs_tick();
        end
    endtask

    typedef struct {
        bit         rst_n;
        bit         preq;
        bit         pnext;
        int         n;
        logic [4:0] outs;
        logic [2:0] pat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int  lat, k;
        bit  bl_seen;
        int  vpos, vper, vlow;
        logic [4:0] mo;

        // outs = {tg_en, panel_disp, bl_en, ready, busy}
        tbl[0] = '{0, 1, 0, 3,  5'b00000, 3'd0};
        tbl[1] = '{1, 1, 0, 1,  5'b00001, 3'd0};
        tbl[2] = '{1, 1, 0, 15, 5'b00001, 3'd0};
        tbl[3] = '{1, 1, 0, 1,  5'b10001, 3'd0};
        tbl[4] = '{1, 0, 0, 1,  5'b00000, 3'd0};
        tbl[5] = '{1, 1, 0, 5,  5'b00001, 3'd0};
        tbl[6] = '{1, 0, 0, 1,  5'b00000, 3'd0};
        tbl[7] = '{1, 0, 1, 1,  5'b00000, 3'd0};
        tbl[8] = '{0, 0, 0, 1,  5'b00000, 3'd0};

        for (int i = 0; i < 9; i++) begin
            nRST         = tbl[i].rst_n;
            power_req    = tbl[i].preq;
            pattern_next = tbl[i].pnext;
            repeat (tbl[i].n) cyc();
            pattern_next = 1'b0;
            check($sformatf("vec%0d", i),
                  {tg_en, panel_disp, bl_en, ready, busy, pattern_sel},
                  {tbl[i].outs, tbl[i].pat});
        end

        // Power-up timing with hand-placed frame boundaries
        nRST = 1'b1;
        cyc();
        power_req = 1'b1;
        lat = 0;
        while (!tg_en && lat < 40) begin
            cyc();
            lat++;
        end
        check("tg_latency", lat, 17);
        repeat (40) cyc();
        vs_tick();
        check("disp_after_1", {tg_en, panel_disp}, 2'b10);
        repeat (40) cyc();
        vs_tick();
        check("disp_after_2", {tg_en, panel_disp, bl_en}, 3'b110);
        repeat (40) cyc();
        vs_tick();
        check("on_state", {bl_en, ready, busy}, 3'b110);

        // Wrap 6 -> 0 with several requests inside one frame
        k = 0;
        while (pattern_sel != 3'd6 && k < 10) begin
            pattern_next = 1'b1;
            cyc();
            pattern_next = 1'b0;
            repeat (5) cyc();
            vs_tick();
            k++;
        end
        check("pat_six", pattern_sel, 3'd6);
        repeat (3) begin
            pattern_next = 1'b1;
            cyc();
            pattern_next = 1'b0;
            repeat (7) cyc();
        end
        check("pat_hold_midframe", pattern_sel, 3'd6);
        LCD_VSYNC = 1'b0;
        cyc();
        check("pat_before_tick", pattern_sel, 3'd6);
        LCD_VSYNC = 1'b1;
        cyc();
        check("pat_wrap", pattern_sel, 3'd0);

`ifdef LCD_PATTERN_AUTO_CYCLE_EN
        repeat (2) begin
            repeat (10) cyc();
            vs_tick();
        end
        check("auto_two_ticks", pattern_sel, 3'd0);
        repeat (10) cyc();
        vs_tick();
        check("auto_third_tick", pattern_sel, 3'd1);
        repeat (10) cyc();
        vs_tick();
        pattern_next = 1'b1;
        cyc();
        pattern_next = 1'b0;
        vs_tick();
        check("auto_manual", pattern_sel, 3'd2);
        repeat (2) begin
            repeat (10) cyc();
            vs_tick();
        end
        check("auto_restart_hold", pattern_sel, 3'd2);
        repeat (10) cyc();
        vs_tick();
        check("auto_restart_fire", pattern_sel, 3'd3);
`endif

        // Orderly shutdown from ON
        power_req = 1'b0;
        cyc();
        check("bl_off", {tg_en, panel_disp, bl_en, ready, busy}, 5'b11001);
        repeat (20) cyc();
        check("bl_off_hold", {tg_en, panel_disp, bl_en, busy}, 4'b1101);
        vs_tick();
        check("disp_off", {tg_en, panel_disp, bl_en, ready, busy}, 5'b10001);
        repeat (20) cyc();
        vs_tick();
        check("off", {tg_en, panel_disp, bl_en, ready, busy}, 5'b00000);

        // Re-request during shutdown is ignored until OFF
        bring_up(lat);
        check("on_again", {ready, busy}, 2'b10);
        power_req = 1'b0;
        cyc();
        power_req = 1'b1;
        repeat (10) cyc();
        check("bl_off_ignore_req", {tg_en, panel_disp, bl_en, busy}, 4'b1101);
        vs_tick();
        check("disp_off_ignore", {tg_en, panel_disp, busy}, 3'b101);
        vs_tick();
        check("off_reached", {tg_en, panel_disp, busy}, 3'b000);
        cyc();
        check("pwr_wait_next", {tg_en, busy}, 2'b01);

        // Abort from DISP_ON skips the backlight
        lat = 0;
        while (!tg_en && lat < 40) begin
            cyc();
            lat++;
        end
        repeat (SF) begin
            repeat (20) cyc();
            vs_tick();
        end
        check("disp_on", {panel_disp, bl_en, busy}, 3'b101);
        power_req = 1'b0;
        cyc();
        check("abort_disp_on", {tg_en, panel_disp, bl_en, busy}, 4'b1001);
        bl_seen = 0;
        repeat (10) begin
            cyc();
            bl_seen |= bl_en;
        end
        vs_tick();
        check("abort_off", {tg_en, busy, bl_seen}, 3'b000);

        // Random stimulus against the model
        nRST = 1'b0;
        repeat (2) cyc();
        nRST = 1'b1;
        vpos = 0;
        vper = 20;
        vlow = 2;
        for (int c = 0; c < 20000 && n_err < 40; c++) begin
            if (vpos >= vper) begin
                vpos = 0;
                vper = $urandom_range(40, 6);
                vlow = $urandom_range(3, 1);
            end
            LCD_VSYNC = (vpos >= vlow);
            vpos++;
            if ($urandom_range(149, 0) == 0) power_req = ~power_req;
            pattern_next = ($urandom_range(15, 0) == 0);
            nRST = ($urandom_range(3999, 0) != 0);
            cyc();
            mo = m_outs(m_ph);
            check("random", {tg_en, panel_disp, bl_en, ready, busy, pattern_sel},
                  {mo, m_pat[2:0]});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
